// File: rtl/tappy_rx.sv
// tappy_rx: oversampled clk/dat serial frame decoder feeding a
// show-ahead FIFO with a valid/ready output handshake.
// Ports: sysclk, rst_n (async, active low)
//        clk, dat         : external serial link, idle high
//        word/valid/ready : FIFO head and handshake
//        level            : FIFO occupancy 0..DEPTH
//        frame_err        : pulse on bad stop/parity/timeout
//        overflow         : pulse when a good frame hits a full FIFO
// Build option: TAPPY_RX_PARITY_EN adds an odd-parity bit.
module tappy_rx #(
  parameter int WIDTH       = 8,
  parameter int MSB_FIRST   = 0,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic                     clk,
  input  logic                     dat,
  output logic [WIDTH-1:0]         word,
  output logic                     valid,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

`ifdef TAPPY_RX_PARITY_EN
  localparam state_t AFTER = PARITY;
`else
  localparam state_t AFTER = STOP;
`endif

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  state_t                 state;
  state_t                 state_d;
  logic [WIDTH-1:0]       sr;
  logic [WIDTH-1:0]       sr_nxt;
  logic [BW-1:0]          bitcnt;
  logic [TW-1:0]          tocnt;
  logic                   tout;
  logic                   last;
  logic                   par_ok;
  logic                   good;
  logic                   bad;

  logic                   push_q;
  logic [WIDTH-1:0]       push_w;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [LW-1:0]          count;
  logic                   full;
  logic                   pop;
  logic                   wr;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], dat};
      clk_prev <= clk_s;
    end
  end

  generate
    if (WIDTH == 1) begin : g_w1
      assign sr_nxt = dat_s;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign sr_nxt = {sr[WIDTH-2:0], dat_s};
    end else begin : g_lsb
      assign sr_nxt = {dat_s, sr[WIDTH-1:1]};
    end
  endgenerate

  assign last = (bitcnt == LAST);
  assign tout = (state != IDLE) && (tocnt == TMAX);

  // State register
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state: timeout wins over a same-cycle edge
  always_comb begin
    state_d = state;
    if (tout) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:    if (!dat_s) state_d = DATA;
        DATA:    if (last) state_d = AFTER;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame outcome
  always_comb begin
    good = 1'b0;
    bad  = 1'b0;
    if (tout) begin
      bad = 1'b1;
    end else if (fall && state == STOP) begin
      if (dat_s && par_ok) good = 1'b1;
      else                 bad  = 1'b1;
    end
  end

`ifdef TAPPY_RX_PARITY_EN
  logic pbit;

  // Odd parity over data plus parity bit
  assign par_ok = (^sr) ^ pbit;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pbit <= 1'b0;
    end else if (!tout && fall && state == PARITY) begin
      pbit <= dat_s;
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      bitcnt <= '0;
      tocnt  <= '0;
    end else begin
      if (state == IDLE || fall || tout) tocnt <= '0;
      else                               tocnt <= tocnt + 1'b1;
      if (!tout && fall) begin
        if (state == IDLE) bitcnt <= '0;
        if (state == DATA) begin
          sr     <= sr_nxt;
          bitcnt <= bitcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      push_q    <= 1'b0;
      push_w    <= '0;
      frame_err <= 1'b0;
    end else begin
      push_q    <= good;
      push_w    <= sr;
      frame_err <= bad;
    end
  end

  assign full  = (count == FULL);
  assign valid = (count != '0);
  assign pop   = valid & ready;
  // A pop frees the slot a full-FIFO push needs
  assign wr    = push_q & (~full | pop);
  assign level = count;
  assign word  = valid ? mem[rptr] : '0;

  always_ff @(posedge sysclk) begin
    if (wr) mem[wptr] <= push_w;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_q & full & ~pop;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_tappy_rx.sv
// tb_tappy_rx: directed frames into tappy_rx with a queue of
// expected words checked as the FIFO is drained.
module tb_tappy_rx;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int TO   = 64;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic          sysclk = 1'b0;
  logic          rst_n  = 1'b1;
  logic          clk    = 1'b1;
  logic          dat    = 1'b1;
  logic          ready  = 1'b0;
  logic [W-1:0]  word;
  logic [W-1:0]  m_word;
  logic          valid;
  logic          m_valid;
  logic [$clog2(D):0] level;
  logic [$clog2(D):0] m_level;
  logic          frame_err;
  logic          overflow;
  logic          m_ferr;
  logic          m_ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int m_cnt  = 0;
  int lat    = -1;
  int f0;
  int o0;
  int m0;
  logic [W-1:0] m_last = '0;
  logic [W-1:0] exp_q[$];

  always #5 sysclk = ~sysclk;

  tappy_rx #(
    .WIDTH(W), .MSB_FIRST(0), .DEPTH(D),
    .TIMEOUT(TO), .SYNC_STAGES(SS)
  ) u_dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .clk(clk), .dat(dat),
    .word(word), .valid(valid), .ready(ready),
    .level(level),
    .frame_err(frame_err), .overflow(overflow)
  );

  tappy_rx #(
    .WIDTH(W), .MSB_FIRST(1), .DEPTH(D),
    .TIMEOUT(TO), .SYNC_STAGES(SS)
  ) u_msb (
    .sysclk(sysclk), .rst_n(rst_n),
    .clk(clk), .dat(dat),
    .word(m_word), .valid(m_valid), .ready(1'b1),
    .level(m_level),
    .frame_err(m_ferr), .overflow(m_ovf)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge sysclk) begin
    if (frame_err) fe_cnt++;
    if (overflow)  ov_cnt++;
    if (m_valid) begin
      m_last = m_word;
      m_cnt++;
    end
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0)
        check("unexpected_pop", {24'd0, word}, 32'hdead);
      else
        check("pop", {24'd0, word}, {24'd0, exp_q.pop_front()});
    end
  end

  // One serial bit: high phase with data set, then low phase.
  // lat = sysclk edges from the raw fall to the first valid.
  task automatic send_bit(input logic b);
    dat = b;
    repeat (HALF) @(posedge sysclk);
    #1 clk = 1'b0;
    lat = -1;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge sysclk);
      if (valid && lat < 0) lat = i - 1;
    end
    @(posedge sysclk);
    #1 clk = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] d,
                            input bit badpar);
`ifdef TAPPY_RX_PARITY_EN
    logic p;
`endif
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
`ifdef TAPPY_RX_PARITY_EN
    p = ~^d;
    if (badpar) p = ~p;
    send_bit(p);
`else
    if (badpar) send_bit(1'b0);
`endif
    send_bit(1'b1);
    dat = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      @(posedge sysclk);
    #1 check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_word", {24'd0, word}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_level", {29'd0, level}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge sysclk);
    #1;

    // Basic frame with immediate consumption
    ready = 1'b1;
    f0 = fe_cnt;
    o0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0);
    check("latency", lat, SS + 2);
    repeat (4) @(posedge sysclk);
    #1;
    check("t1_level", {29'd0, level}, 0);
    check("t1_drain", exp_q.size(), 0);
    check("t1_ferr", fe_cnt - f0, 0);
    check("t1_ovf", ov_cnt - o0, 0);

    // MSB-first instance
    m0 = m_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0);
    check("msb_cnt", m_cnt - m0, 1);
    check("msb_3c", {24'd0, m_last}, 32'h3C);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b0);
    check("msb_80", {24'd0, m_last}, 32'h80);
    wait_drain("msb_drain");

    // Bad parity (or bad stop without parity)
    f0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    repeat (4) @(posedge sysclk);
    #1;
    check("par_ferr", fe_cnt - f0, 1);
    check("par_level", {29'd0, level}, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0);
    wait_drain("par_drain");

    // Overflow with consumer stalled
    ready = 1'b0;
    o0 = ov_cnt;
    for (int v = 1; v <= 5; v++) begin
      if (v <= D) exp_q.push_back(W'(v));
      send_frame(W'(v), 1'b0);
    end
    repeat (4) @(posedge sysclk);
    #1;
    check("ovf_level", {29'd0, level}, D);
    check("ovf_pulse", ov_cnt - o0, 1);
    ready = 1'b1;
    wait_drain("ovf_drain");
    repeat (2) @(posedge sysclk);
    #1 check("ovf_empty", {29'd0, level}, 0);

    // Timeout after 3 data bits
    f0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    dat = 1'b1;
    repeat (TO + 16) @(posedge sysclk);
    #1;
    check("to_ferr", fe_cnt - f0, 1);
    check("to_valid", {31'd0, valid}, 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0);
    wait_drain("to_drain");

    // Reset mid-frame with two words buffered
    ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    repeat (4) @(posedge sysclk);
    #1 check("rst2_level_pre", {29'd0, level}, 2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_valid", {31'd0, valid}, 0);
    check("rst2_level", {29'd0, level}, 0);
    exp_q.delete();
    dat = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 ready = 1'b1;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b0);
    wait_drain("rst2_drain");
    repeat (2) @(posedge sysclk);
    #1 check("end_level", {29'd0, level}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
